ps2_joypad: RTL and testbench
=============================

# ps2_joypad

Converts a PS/2 keyboard into the two 8-bit Dendy joypad states consumed by the PPU's `joy1`/`joy2` inputs. It sits directly upstream of the PPU I/O port logic, in the `clock_25` domain. It samples raw PS/2 lines, deframes scancodes, tracks E0/F0 prefixes and keeps a held/released bit per mapped key.

## Interface
- `TIMEOUT`, default 25000: idle clocks (1 ms at 25 MHz) after which a partial frame is abandoned.
- `clock`  in  1: system clock (`clock_25`).
- `reset_n`  in  1: asynchronous, active-low reset.
- `ps2_clk`  in  1: raw PS/2 clock, asynchronous. Receive only; never driven.
- `ps2_dat`  in  1: raw PS/2 data, asynchronous.
- `joy1`  out  8: player 1 buttons, 1 = pressed. Bit0 A, bit1 B, bit2 Select, bit3 Start, bit4 Up, bit5 Down, bit6 Left, bit7 Right.
- `joy2`  out  8: player 2 buttons, same bit order.
- `kbd_byte`  out  8: last correctly received byte (debug).
- `kbd_valid`  out  1: 1-cycle strobe when `kbd_byte` updates.
- `err`  out  1: 1-cycle strobe on a framing, parity or timeout error.

## Operation
- Reset values: `joy1`=`joy2`=8'h00, `kbd_byte`=8'h00, `kbd_valid`=`err`=0. Receiver idle, prefix flags clear.
- Input sync: both lines pass through 2-flop synchronizers. Falling edge = sync'd clk was 1 last cycle and is 0 now. Data is sampled on that edge.
- Receiver FSM: IDLE → DATA (8 bits, LSB first) → PARITY → STOP → IDLE.
  - IDLE: a falling edge with data 0 enters DATA. Data 1 stays in IDLE (no `err`).
  - Byte accepted only if parity is odd over data+parity and the stop bit is 1. Otherwise pulse `err`, discard the byte, clear both prefix flags.
- Timeout: outside IDLE, a counter counts cycles since the last falling edge. At `TIMEOUT` it returns to IDLE and pulses `err`. Prefix flags are kept.
- Decoder, per accepted byte:
  - E0: set `ext`.
  - F0: set `rel`.
  - E1: ignored; flags unchanged.
  - AA: clear `joy1`, `joy2` and both flags (keyboard BAT/reset).
  - Any other byte: look up {`ext`, code}. If mapped, write `~rel` to that bit. Then clear both flags. Unmapped codes only clear the flags.
- Map, joy1: 1A Z→A; 22 X→B; 29 Space→Select; 5A Enter→Start; E0 75 Up; E0 72 Down; E0 6B Left; E0 74 Right.
- Map, joy2: 34 G→A; 2B F→B; 16 '1'→Select; 1E '2'→Start; 1D W→Up; 1B S→Down; 1C A→Left; 23 D→Right.
- Non-extended 75/72/6B/74 (keypad) are unmapped.
- Buttons are independent. Opposite directions may both be 1; no SOCD filtering.

## Timing
- Stop-bit falling edge detected at cycle N: `kbd_byte`/`kbd_valid` at N+1, `joy*` bit update at N+2. `err` for a bad frame asserts at N+1.
- Timeout `err` asserts on the cycle the counter reaches `TIMEOUT`. The receiver is in IDLE on the next cycle.
- Sync latency is 2 cycles from `ps2_clk` pin to the edge-detect register. The PS/2 clock at 10–16.7 kHz gives ≥1500 cycles per bit; no oversampling needed.
- `reset_n` low mid-frame clears everything immediately, asynchronously. The remaining bits are seen while in IDLE; a data-0 bit among them can start a spurious frame, which must end in `err` or timeout and never change `joy*`.
- Timeout count and an accepted edge in the same cycle: the edge wins and the counter restarts.

## Structure
- Shared package `ps2_pkg`: scancode constants (E0, F0, E1, AA, all mapped codes), joypad bit indices, FSM state encoding.
- Sub-module `ps2_rx`: sync, edge detect, frame FSM, timeout. Outputs byte + valid + err.
- Top `ps2_joypad`: prefix flags, map decoder, `joy1`/`joy2` registers.

## Test plan
- Frame 1A (parity bit 0) → `kbd_byte`=1A strobe, `joy1`=01. Then F0,1A → `joy1`=00.
- E0,75 then 1D → `joy1`=10, `joy2`=10. Then E0,F0,75 → `joy1`=00, `joy2` still 10.
- Frame 1A with parity bit 1 → `err` pulse, `joy1` unchanged 00. Following F0 is treated as a fresh prefix.
- 5 bits of a frame then idle `TIMEOUT` cycles → `err` pulse. Next full frame 22 → `joy1`=02.
- Press Z, X, Enter (`joy1`=0B), then AA → `joy1`=`joy2`=00.
- Assert `reset_n` mid-frame after press of G → all outputs 00 immediately. Residual bits produce no `joy*` change.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 keyboard constants: scancodes, joypad bit indices, receiver states.
package ps2_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_DATA, ST_PARITY, ST_STOP} rx_state_t;

  // Prefix / control scancodes
  localparam logic [7:0] SC_EXT = 8'hE0;
  localparam logic [7:0] SC_REL = 8'hF0;
  localparam logic [7:0] SC_PAU = 8'hE1;
  localparam logic [7:0] SC_BAT = 8'hAA;

  // Player 1 keys (arrows are E0-prefixed)
  localparam logic [7:0] SC_Z     = 8'h1A;
  localparam logic [7:0] SC_X     = 8'h22;
  localparam logic [7:0] SC_SPACE = 8'h29;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;

  // Player 2 keys
  localparam logic [7:0] SC_G  = 8'h34;
  localparam logic [7:0] SC_F  = 8'h2B;
  localparam logic [7:0] SC_1  = 8'h16;
  localparam logic [7:0] SC_2  = 8'h1E;
  localparam logic [7:0] SC_W  = 8'h1D;
  localparam logic [7:0] SC_S  = 8'h1B;
  localparam logic [7:0] SC_A  = 8'h1C;
  localparam logic [7:0] SC_D  = 8'h23;

  // Joypad bit indices
  localparam logic [2:0] BTN_A     = 3'd0;
  localparam logic [2:0] BTN_B     = 3'd1;
  localparam logic [2:0] BTN_SEL   = 3'd2;
  localparam logic [2:0] BTN_START = 3'd3;
  localparam logic [2:0] BTN_UP    = 3'd4;
  localparam logic [2:0] BTN_DOWN  = 3'd5;
  localparam logic [2:0] BTN_LEFT  = 3'd6;
  localparam logic [2:0] BTN_RIGHT = 3'd7;

  typedef struct packed {
    logic       hit;
    logic       p2;
    logic [2:0] idx;
  } key_map_t;

  // {ext, code} -> joypad bit; keypad codes without E0 fall through unmapped
  function automatic key_map_t map_key(input logic ext, input logic [7:0] code);
    key_map_t m;
    m = '0;
    case ({ext, code})
      {1'b0, SC_Z}:     m = '{1'b1, 1'b0, BTN_A};
      {1'b0, SC_X}:     m = '{1'b1, 1'b0, BTN_B};
      {1'b0, SC_SPACE}: m = '{1'b1, 1'b0, BTN_SEL};
      {1'b0, SC_ENTER}: m = '{1'b1, 1'b0, BTN_START};
      {1'b1, SC_UP}:    m = '{1'b1, 1'b0, BTN_UP};
      {1'b1, SC_DOWN}:  m = '{1'b1, 1'b0, BTN_DOWN};
      {1'b1, SC_LEFT}:  m = '{1'b1, 1'b0, BTN_LEFT};
      {1'b1, SC_RIGHT}: m = '{1'b1, 1'b0, BTN_RIGHT};
      {1'b0, SC_G}:     m = '{1'b1, 1'b1, BTN_A};
      {1'b0, SC_F}:     m = '{1'b1, 1'b1, BTN_B};
      {1'b0, SC_1}:     m = '{1'b1, 1'b1, BTN_SEL};
      {1'b0, SC_2}:     m = '{1'b1, 1'b1, BTN_START};
      {1'b0, SC_W}:     m = '{1'b1, 1'b1, BTN_UP};
      {1'b0, SC_S}:     m = '{1'b1, 1'b1, BTN_DOWN};
      {1'b0, SC_A}:     m = '{1'b1, 1'b1, BTN_LEFT};
      {1'b0, SC_D}:     m = '{1'b1, 1'b1, BTN_RIGHT};
      default:          m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: sync, falling-edge detect, 11-bit deframer, idle timeout.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT = 25000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       rx_ferr,
  output logic       rx_terr
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_s, dat_s;
  logic          clk_d;
  logic          fall, din;
  rx_state_t     state, state_nx;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          par;
  logic [CW-1:0] cnt;

  assign fall = clk_d & ~clk_s[1];
  assign din  = dat_s[1];
  // Edge wins over a coincident timeout
  assign rx_terr = (state != ST_IDLE) && (cnt == CW'(TIMEOUT)) && !fall;

  // Two-flop synchronizers plus edge-detect history; idle lines are high
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      clk_s <= 2'b11;
      dat_s <= 2'b11;
      clk_d <= 1'b1;
    end else begin
      clk_s <= {clk_s[0], ps2_clk};
      dat_s <= {dat_s[0], ps2_dat};
      clk_d <= clk_s[1];
    end
  end

  // Frame state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // Next-state: advance on each falling edge, abandon on timeout
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (fall && !din)           state_nx = ST_DATA;
      ST_DATA:   if (fall && bit_cnt == 3'd7) state_nx = ST_PARITY;
      ST_PARITY: if (fall)                   state_nx = ST_STOP;
      ST_STOP:   if (fall)                   state_nx = ST_IDLE;
      default:                               state_nx = ST_IDLE;
    endcase
    if (rx_terr) state_nx = ST_IDLE;
  end

  // Shift data LSB first, capture parity, check the frame at the stop bit
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      shreg    <= '0;
      par      <= 1'b0;
      rx_byte  <= '0;
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      rx_valid <= 1'b0;
      rx_ferr  <= 1'b0;
      if (fall) begin
        case (state)
          ST_IDLE:   bit_cnt <= '0;
          ST_DATA: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
          end
          ST_PARITY: par <= din;
          ST_STOP: begin
            if (din && (^{shreg, par})) begin
              rx_byte  <= shreg;
              rx_valid <= 1'b1;
            end else begin
              rx_ferr <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Cycles since the last falling edge while a frame is open (saturating)
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)                          cnt <= '0;
    else if (state == ST_IDLE || fall)     cnt <= '0;
    else if (cnt != CW'(TIMEOUT))          cnt <= cnt + CW'(1);
  end

endmodule

// File: rtl/ps2_joypad.sv
// PS/2 keyboard to two Dendy joypad states: prefix tracking and key map.
module ps2_joypad
  import ps2_pkg::*;
#(
  parameter int TIMEOUT = 25000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] joy1,
  output logic [7:0] joy2,
  output logic [7:0] kbd_byte,
  output logic       kbd_valid,
  output logic       err
);

  logic       rx_valid, rx_ferr, rx_terr;
  logic [7:0] rx_byte;
  logic       ext, rel;
  key_map_t   km;

  ps2_rx #(.TIMEOUT(TIMEOUT)) u_rx (
    .clock    (clock),
    .reset_n  (reset_n),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .rx_byte  (rx_byte),
    .rx_valid (rx_valid),
    .rx_ferr  (rx_ferr),
    .rx_terr  (rx_terr)
  );

  assign kbd_byte  = rx_byte;
  assign kbd_valid = rx_valid;
  assign err       = rx_ferr | rx_terr;
  assign km        = map_key(ext, rx_byte);

  // Decode accepted bytes; a bad frame drops any pending prefix, a timeout keeps it
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ext  <= 1'b0;
      rel  <= 1'b0;
      joy1 <= '0;
      joy2 <= '0;
    end else if (rx_valid) begin
      case (rx_byte)
        SC_EXT: ext <= 1'b1;
        SC_REL: rel <= 1'b1;
        SC_PAU: ;
        SC_BAT: begin
          ext  <= 1'b0;
          rel  <= 1'b0;
          joy1 <= '0;
          joy2 <= '0;
        end
        default: begin
          if (km.hit) begin
            if (km.p2) joy2[km.idx] <= ~rel;
            else       joy1[km.idx] <= ~rel;
          end
          ext <= 1'b0;
          rel <= 1'b0;
        end
      endcase
    end else if (rx_ferr) begin
      ext <= 1'b0;
      rel <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ps2_joypad.sv
// Scoreboard bench: stimulus pushes expected strobes, a monitor pops and compares.
module tb_ps2_joypad;

  localparam int TO = 300;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic [7:0] joy1, joy2, kbd_byte;
  logic       kbd_valid, err;

  ps2_joypad #(.TIMEOUT(TO)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .joy1      (joy1),
    .joy2      (joy2),
    .kbd_byte  (kbd_byte),
    .kbd_valid (kbd_valid),
    .err       (err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       e;
    logic [7:0] b;
    logic [7:0] j1;
    logic [7:0] j2;
  } exp_t;

  exp_t q[$];
  int   nvec = 0;
  int   nbad = 0;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
    nvec++;
    if (act !== want) begin
      nbad++;
      $display("FAIL %s: got %h want %h", name, act, want);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
  endtask

  task automatic send_bit(input logic b);
    ps2_dat = b;
    tick(10);
    ps2_clk = 1'b0;
    tick(20);
    ps2_clk = 1'b1;
    tick(10);
  endtask

  function automatic logic [10:0] frame(input logic [7:0] d, input logic pflip, input logic stop);
    return {stop, (~(^d)) ^ pflip, d, 1'b0};
  endfunction

  task automatic send_frame(input logic [10:0] f);
    for (int i = 0; i < 11; i++) send_bit(f[i]);
    ps2_dat = 1'b1;
    tick(60);
  endtask

  // Good byte; j1/j2 are the joypad states expected after decoding it
  task automatic key(input logic [7:0] d, input logic [7:0] j1, input logic [7:0] j2);
    q.push_back('{1'b0, d, j1, j2});
    send_frame(frame(d, 1'b0, 1'b1));
  endtask

  task automatic bad(input logic [7:0] d, input logic pflip, input logic stop,
                     input logic [7:0] j1, input logic [7:0] j2);
    q.push_back('{1'b1, 8'h00, j1, j2});
    send_frame(frame(d, pflip, stop));
  endtask

  // Monitor: every strobe must match the head of the queue; joypads checked a cycle later
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (kbd_valid || err) begin
        if (q.size() == 0) begin
          nvec++;
          nbad++;
          $display("FAIL unexpected_strobe: got valid=%b err=%b byte=%h want none", kbd_valid, err, kbd_byte);
        end else begin
          e = q.pop_front();
          chk("strobe_kind", {7'b0, err}, {7'b0, e.e});
          if (!e.e) chk("kbd_byte", kbd_byte, e.b);
          @(negedge clock);
          chk("joy1", joy1, e.j1);
          chk("joy2", joy2, e.j2);
        end
      end
    end
  end

  initial begin
    logic [10:0] f;
    tick(3);
    #1;
    chk("rst_joy1", joy1, 8'h00);
    chk("rst_joy2", joy2, 8'h00);
    chk("rst_byte", kbd_byte, 8'h00);
    chk("rst_strobes", {6'b0, kbd_valid, err}, 8'h00);
    reset_n = 1'b1;
    tick(20);

    // Press / release Z
    key(8'h1A, 8'h01, 8'h00);
    key(8'hF0, 8'h01, 8'h00);
    key(8'h1A, 8'h00, 8'h00);
    // Extended Up, W, extended release of Up
    key(8'hE0, 8'h00, 8'h00);
    key(8'h75, 8'h10, 8'h00);
    key(8'h1D, 8'h10, 8'h10);
    key(8'hE0, 8'h10, 8'h10);
    key(8'hF0, 8'h10, 8'h10);
    key(8'h75, 8'h00, 8'h10);
    // Parity error drops a pending E0; then F0 is a fresh prefix
    key(8'hE0, 8'h00, 8'h10);
    bad(8'h1A, 1'b1, 1'b1, 8'h00, 8'h10);
    key(8'h75, 8'h00, 8'h10);
    key(8'hF0, 8'h00, 8'h10);
    key(8'h1D, 8'h00, 8'h00);
    // Partial frame abandoned by timeout, then a good frame
    q.push_back('{1'b1, 8'h00, 8'h00, 8'h00});
    f = frame(8'h22, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) send_bit(f[i]);
    ps2_dat = 1'b1;
    tick(TO + 100);
    key(8'h22, 8'h02, 8'h00);
    // Z, Enter, A(left p2), then BAT clears everything
    key(8'h1A, 8'h03, 8'h00);
    key(8'h5A, 8'h0B, 8'h00);
    key(8'h1C, 8'h0B, 8'h40);
    key(8'hAA, 8'h00, 8'h00);
    // Keypad code unmapped; E1 leaves E0 pending; F0 then E0 both apply
    key(8'h72, 8'h00, 8'h00);
    key(8'hE0, 8'h00, 8'h00);
    key(8'hE1, 8'h00, 8'h00);
    key(8'h75, 8'h10, 8'h00);
    key(8'hF0, 8'h10, 8'h00);
    key(8'hE0, 8'h10, 8'h00);
    key(8'h75, 8'h00, 8'h00);
    // Bad stop bit
    bad(8'h22, 1'b0, 1'b0, 8'h00, 8'h00);
    key(8'h22, 8'h02, 8'h00);
    key(8'hF0, 8'h02, 8'h00);
    key(8'h22, 8'h00, 8'h00);
    // Opposite directions coexist; remaining keys
    key(8'h1D, 8'h00, 8'h10);
    key(8'h1B, 8'h00, 8'h30);
    key(8'h6B, 8'h00, 8'h30);
    key(8'hE0, 8'h00, 8'h30);
    key(8'h6B, 8'h40, 8'h30);
    key(8'hE0, 8'h40, 8'h30);
    key(8'h74, 8'hC0, 8'h30);
    key(8'h2B, 8'hC0, 8'h32);
    key(8'h16, 8'hC0, 8'h36);
    key(8'h1E, 8'hC0, 8'h3E);
    key(8'h23, 8'hC0, 8'hBE);
    key(8'h29, 8'hC4, 8'hBE);
    key(8'hE0, 8'hC4, 8'hBE);
    key(8'h72, 8'hE4, 8'hBE);
    key(8'hAA, 8'h00, 8'h00);
    key(8'h34, 8'h00, 8'h01);
    // Reset mid-frame; residual bits form a spurious frame that times out
    f = frame(8'h1A, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) send_bit(f[i]);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_joy1", joy1, 8'h00);
    chk("mid_rst_joy2", joy2, 8'h00);
    chk("mid_rst_byte", kbd_byte, 8'h00);
    tick(2);
    reset_n = 1'b1;
    q.push_back('{1'b1, 8'h00, 8'h00, 8'h00});
    for (int i = 4; i < 11; i++) send_bit(f[i]);
    ps2_dat = 1'b1;
    tick(TO + 100);
    chk("post_rst_joy1", joy1, 8'h00);
    chk("post_rst_joy2", joy2, 8'h00);

    // Drain: every expected strobe must have been seen
    for (int i = 0; i < 2000 && q.size() != 0; i++) tick(1);
    chk("pending_expect", 8'(q.size()), 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
